// File: rtl/telemetry_uart_tx_pkg.sv
// rtl/telemetry_uart_tx_pkg.sv - shared UART line constants, frame layout and FSM encoding
package telemetry_uart_tx_pkg;

  localparam int CLK_FREQ  = 50000000;
  localparam int BAUD_RATE = 9600;
  localparam int BAUD_TICK = CLK_FREQ / BAUD_RATE;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         FRAME_LEN = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic logic [7:0] frame_checksum(input logic [7:0] x, input logic [7:0] y);
    return FRAME_HDR ^ x ^ y;
  endfunction

endpackage

// File: rtl/telemetry_uart_tx_byte.sv
// rtl/telemetry_uart_tx_byte.sv - 8N1 byte serializer (module uart_tx_byte) with baud counter
module uart_tx_byte
  import telemetry_uart_tx_pkg::*;
#(
  parameter int BAUD_TICK = telemetry_uart_tx_pkg::BAUD_TICK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_done,
  output logic       uart_tx
);

  localparam int CNT_W = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_TICK - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             accept;

  // byte_done marks the last cycle of the stop bit so a new byte can load with no gap
  assign byte_done = (state_q == ST_STOP) && (cnt_q == '0);
  assign accept    = byte_valid && ((state_q == ST_IDLE) || byte_done);
  assign uart_tx   = tx_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    case (state_q)
      ST_START: begin
        if (cnt_q == '0) begin
          state_d   = ST_DATA;
          cnt_d     = CNT_RELOAD;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = CNT_RELOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        tx_d = 1'b1;
      end
    endcase
    if (accept) begin
      state_d   = ST_START;
      cnt_d     = CNT_RELOAD;
      bit_idx_d = 3'd0;
      shift_d   = byte_data;
      tx_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: rtl/telemetry_uart_tx.sv
// rtl/telemetry_uart_tx.sv - 4-byte telemetry frame sequencer (header, X, Y, checksum) over UART
module telemetry_uart_tx
  import telemetry_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ  = telemetry_uart_tx_pkg::CLK_FREQ,
  parameter int BAUD_RATE = telemetry_uart_tx_pkg::BAUD_RATE,
  parameter int BAUD_TICK = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk50mhz,
  input  logic       rst,
  input  logic [7:0] tx_x,
  input  logic [7:0] tx_y,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       busy
);

  logic       active_q, active_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic       frame_accept;
  logic       byte_valid;
  logic       byte_done;
  logic [7:0] byte_data;

  assign tx_ready     = !active_q;
  assign busy         = active_q;
  assign frame_accept = tx_valid && !active_q;
  assign byte_valid   = frame_accept ||
                        (active_q && byte_done && (byte_idx_q != 2'(FRAME_LEN - 1)));

  // byte_idx_q is the byte currently on the line, so the next one is idx+1
  always_comb begin
    byte_data = FRAME_HDR;
    if (!frame_accept) begin
      case (byte_idx_q)
        2'd0:    byte_data = x_q;
        2'd1:    byte_data = y_q;
        default: byte_data = frame_checksum(x_q, y_q);
      endcase
    end
  end

  always_comb begin
    active_d   = active_q;
    byte_idx_d = byte_idx_q;
    x_d        = x_q;
    y_d        = y_q;
    if (frame_accept) begin
      active_d   = 1'b1;
      byte_idx_d = 2'd0;
      x_d        = tx_x;
      y_d        = tx_y;
    end else if (active_q && byte_done) begin
      if (byte_idx_q == 2'(FRAME_LEN - 1)) begin
        active_d   = 1'b0;
        byte_idx_d = 2'd0;
      end else begin
        byte_idx_d = byte_idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      active_q   <= 1'b0;
      byte_idx_q <= 2'd0;
      x_q        <= 8'h00;
      y_q        <= 8'h00;
    end else begin
      active_q   <= active_d;
      byte_idx_q <= byte_idx_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  uart_tx_byte #(
    .BAUD_TICK(BAUD_TICK)
  ) u_byte (
    .clk       (clk50mhz),
    .rst       (rst),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_done (byte_done),
    .uart_tx   (uart_tx)
  );

endmodule

// File: tb/tb_telemetry_uart_tx.sv
// tb/tb_telemetry_uart_tx.sv - scoreboard bench for telemetry_uart_tx at a reduced baud tick
module tb_telemetry_uart_tx;

  localparam int BT    = 16;
  localparam int FRAME = 40 * BT;
  localparam int BOUND = 4 * FRAME;

  logic       clk50mhz = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_x = 8'h00;
  logic [7:0] tx_y = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_tx;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int         starts_q[$];
  int         skip_req = 0;
  int         skip_done = 0;
  logic       mon_en = 1'b0;

  telemetry_uart_tx #(
    .CLK_FREQ (160000),
    .BAUD_RATE(10000),
    .BAUD_TICK(BT)
  ) dut (
    .clk50mhz(clk50mhz),
    .rst     (rst),
    .tx_x    (tx_x),
    .tx_y    (tx_y),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .uart_tx (uart_tx),
    .busy    (busy)
  );

  always #5 clk50mhz = ~clk50mhz;
  always @(posedge clk50mhz) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Receiver/monitor: samples each bit mid-period and pops the scoreboard per byte
  initial begin : monitor
    logic       prev;
    logic [7:0] data;
    logic       start_bit;
    logic       stop_bit;
    prev = 1'b1;
    forever begin
      @(negedge clk50mhz);
      if (mon_en && prev && !uart_tx) begin
        starts_q.push_back(cyc);
        repeat (BT / 2) @(negedge clk50mhz);
        start_bit = uart_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BT) @(negedge clk50mhz);
          data[i] = uart_tx;
        end
        repeat (BT) @(negedge clk50mhz);
        stop_bit = uart_tx;
        if (skip_req != skip_done) begin
          skip_done++;
        end else begin
          check("start_bit", {31'd0, start_bit}, 32'd0);
          check("stop_bit", {31'd0, stop_bit}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%0h required=none", data);
          end else begin
            check("rx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
          end
        end
      end
      prev = uart_tx;
    end
  end

  task automatic push_frame(input logic [7:0] x, input logic [7:0] y, input logic [7:0] ck);
    exp_q.push_back(8'hA5);
    exp_q.push_back(x);
    exp_q.push_back(y);
    exp_q.push_back(ck);
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk50mhz);
    tx_x = x;
    tx_y = y;
    tx_valid = 1'b1;
    @(posedge clk50mhz);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input string name, output int n);
    n = 0;
    while (busy !== lvl && n < BOUND) begin
      @(posedge clk50mhz);
      #1 n++;
    end
    if (n >= BOUND) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=%0d required=<%0d", name, n, BOUND);
    end
  endtask

  initial begin : stim
    int n;
    int bad_idle;
    int bad_ready;
    repeat (3) @(posedge clk50mhz);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // idle after reset
    bad_idle = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk50mhz);
      if (uart_tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) bad_idle++;
    end
    check("idle_after_reset", bad_idle, 0);

    // basic frame with busy length and start-bit latency
    push_frame(8'h80, 8'h40, 8'h65);
    send(8'h80, 8'h40);
    check("start_bit_latency", {31'd0, uart_tx}, 32'd0);
    check("ready_low_after_accept", {31'd0, tx_ready}, 32'd0);
    n = 0;
    while (busy === 1'b1 && n < BOUND) begin
      n++;
      @(posedge clk50mhz);
      #1;
    end
    check("busy_cycles", n, FRAME);
    check("idle_line_after_frame", {31'd0, uart_tx}, 32'd1);
    repeat (20) @(posedge clk50mhz);

    // inputs changed mid-frame are not used
    push_frame(8'hFF, 8'h00, 8'h5A);
    send(8'hFF, 8'h00);
    tx_x = 8'h11;
    tx_y = 8'h22;
    wait_busy(1'b0, "frame2", n);
    repeat (20) @(posedge clk50mhz);

    // second request while busy is ignored
    push_frame(8'h12, 8'h34, 8'h83);
    send(8'h12, 8'h34);
    bad_ready = 0;
    repeat (100) begin
      @(negedge clk50mhz);
      if (tx_ready !== 1'b0) bad_ready++;
    end
    tx_x = 8'h55;
    tx_y = 8'h66;
    tx_valid = 1'b1;
    @(negedge clk50mhz);
    tx_valid = 1'b0;
    while (busy === 1'b1) begin
      @(negedge clk50mhz);
      if (tx_ready !== ~busy) bad_ready++;
    end
    check("ready_low_while_busy", bad_ready, 0);
    repeat (FRAME + 60) @(posedge clk50mhz);
    check("ignored_request_no_frame", {31'd0, busy}, 32'd0);

    // reset mid-frame, with tx_valid presented alongside rst
    exp_q.push_back(8'hA5);
    send(8'h01, 8'h02);
    repeat (250) @(posedge clk50mhz);
    #1;
    skip_req++;
    rst = 1'b1;
    tx_valid = 1'b1;
    @(posedge clk50mhz);
    #1;
    rst = 1'b0;
    tx_valid = 1'b0;
    check("abort_line_high", {31'd0, uart_tx}, 32'd1);
    check("abort_ready", {31'd0, tx_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (200) @(posedge clk50mhz);
    check("no_resume_after_abort", {31'd0, busy}, 32'd0);
    push_frame(8'h33, 8'h44, 8'hD2);
    send(8'h33, 8'h44);
    wait_busy(1'b0, "frame_after_abort", n);
    repeat (200) @(posedge clk50mhz);

    // tx_valid held: two back-to-back frames
    starts_q.delete();
    push_frame(8'hC3, 8'h3C, 8'h5A);
    push_frame(8'hC3, 8'h3C, 8'h5A);
    @(negedge clk50mhz);
    tx_x = 8'hC3;
    tx_y = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk50mhz);
    #1;
    wait_busy(1'b1, "held_first", n);
    wait_busy(1'b0, "held_end1", n);
    wait_busy(1'b1, "held_second", n);
    check("idle_gap_cycles", n, 1);
    tx_valid = 1'b0;
    wait_busy(1'b0, "held_end2", n);
    repeat (200) @(posedge clk50mhz);
    check("held_byte_count", starts_q.size(), 8);
    if (starts_q.size() >= 8) begin
      check("inter_byte_spacing", starts_q[1] - starts_q[0], 10 * BT);
      check("frame1_span", starts_q[3] - starts_q[0], 30 * BT);
      check("frame_gap_start", starts_q[4] - starts_q[3], 10 * BT + 1);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
